// File: rtl/video_pattern_gen_if.sv
// Pixel-domain bundle between the pattern generator and its consumer:
// mode control flows into the generator, timed RGB video flows out.
interface video_pattern_gen_if #(
  parameter int CW = 8,
  parameter int XW = 12
);
  logic [1:0]      mode_in;
  logic            mode_apply;
  logic [3*CW-1:0] solid_rgb;
  logic [CW-1:0]   R_data;
  logic [CW-1:0]   G_data;
  logic [CW-1:0]   B_data;
  logic            VDE;
  logic            hsync;
  logic            vsync;
  logic [XW-1:0]   x;
  logic [XW-1:0]   y;
  logic            frame_start;
  logic [7:0]      frame_cnt;

  // The generator sources the video stream and consumes the mode controls.
  modport master (
    input  mode_in, mode_apply, solid_rgb,
    output R_data, G_data, B_data, VDE, hsync, vsync, x, y, frame_start, frame_cnt
  );

  modport slave (
    output mode_in, mode_apply, solid_rgb,
    input  R_data, G_data, B_data, VDE, hsync, vsync, x, y, frame_start, frame_cnt
  );
endinterface

// File: rtl/video_pattern_gen.sv
// HDMI video source: raster timing generator plus a frame-synchronous RGB
// pattern engine. All outputs are registered one cycle behind the counters.
module video_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CW         = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int SYNC_POL   = 0,
  parameter int XW         = 12
) (
  input  logic               pixclk,
  input  logic               rst,
  video_pattern_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int BW      = H_ACTIVE / 8;
  localparam int BWW     = (BW > 1) ? $clog2(BW) : 1;
  localparam int BAR_W   = 2 ** CHECK_LOG2;

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] POS_LAST = HCW'(H_ACTIVE - 1);
  localparam logic [BWW-1:0] BW_LOAD  = BWW'(BW - 1);
  localparam logic           SYNC_ON  = 1'(SYNC_POL);
  localparam logic           SYNC_OFF = ~SYNC_ON;

  logic [HCW-1:0]  r_h_cnt;
  logic [VCW-1:0]  r_v_cnt;
  logic [BWW-1:0]  r_bw_cnt;
  logic [2:0]      r_bar_idx;
  logic            r_bars_done;
  logic [HCW-1:0]  r_bar_pos;
  logic [1:0]      r_pending_mode;
  logic [1:0]      r_active_mode;
  logic [7:0]      r_frame_cnt;
  logic [CW-1:0]   r_r_data;
  logic [CW-1:0]   r_g_data;
  logic [CW-1:0]   r_b_data;
  logic            r_vde;
  logic            r_hsync;
  logic            r_vsync;
  logic [XW-1:0]   r_x;
  logic [XW-1:0]   r_y;
  logic            r_frame_start;

  logic            w_h_last;
  logic            w_v_last;
  logic            w_boundary;
  logic [31:0]     w_h32;
  logic [31:0]     w_v32;
  logic [31:0]     w_pos32;
  logic            w_vde;
  logic            w_hs_act;
  logic            w_vs_act;
  logic            w_in_bar;
  logic [2:0]      w_bar_rgb;
  logic [3*CW-1:0] w_rgb;

  // Bar index -> {R,G,B} on/off: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      3'd7:    c = 3'b000;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  assign w_h_last   = (r_h_cnt == H_LAST);
  assign w_v_last   = (r_v_cnt == V_LAST);
  assign w_boundary = w_h_last && w_v_last;
  assign w_h32      = 32'(r_h_cnt);
  assign w_v32      = 32'(r_v_cnt);
  assign w_pos32    = 32'(r_bar_pos);
  assign w_vde      = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
  assign w_hs_act   = (w_h32 >= 32'(H_ACTIVE + H_FP)) && (w_h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_act   = (w_v32 >= 32'(V_ACTIVE + V_FP)) && (w_v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign w_in_bar   = (w_h32 >= w_pos32) && (w_h32 < (w_pos32 + 32'(BAR_W)));
  assign w_bar_rgb  = bar_colour(r_bar_idx);

  // Raster position counters.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= {HCW{1'b0}};
      r_v_cnt <= {VCW{1'b0}};
    end else if (w_h_last) begin
      r_h_cnt <= {HCW{1'b0}};
      r_v_cnt <= w_v_last ? {VCW{1'b0}} : (r_v_cnt + VCW'(1));
    end else begin
      r_h_cnt <= r_h_cnt + HCW'(1);
    end
  end

  // Colour-bar tracker: width down-counter and bar index, reloaded as the line restarts.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_bw_cnt    <= BW_LOAD;
      r_bar_idx   <= 3'd0;
      r_bars_done <= 1'b0;
    end else if (w_h_last) begin
      r_bw_cnt    <= BW_LOAD;
      r_bar_idx   <= 3'd0;
      r_bars_done <= 1'b0;
    end else if (r_bw_cnt == {BWW{1'b0}}) begin
      r_bw_cnt <= BW_LOAD;
      if (r_bar_idx == 3'd7) begin
        r_bars_done <= 1'b1;
      end else begin
        r_bar_idx <= r_bar_idx + 3'd1;
      end
    end else begin
      r_bw_cnt <= r_bw_cnt - BWW'(1);
    end
  end

  // Mode requests are parked in pending_mode; the active mode only moves at the frame boundary.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_pending_mode <= 2'd0;
      r_active_mode  <= 2'd0;
    end else begin
      if (vid.mode_apply) begin
        r_pending_mode <= vid.mode_in;
      end
      if (w_boundary) begin
        r_active_mode <= vid.mode_apply ? vid.mode_in : r_pending_mode;
      end
    end
  end

  // Per-frame state: completed-frame count and moving-bar position.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 8'd0;
      r_bar_pos   <= {HCW{1'b0}};
    end else if (w_boundary) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
      r_bar_pos   <= (r_bar_pos == POS_LAST) ? {HCW{1'b0}} : (r_bar_pos + HCW'(1));
    end
  end

  // Pattern selection for the current raster position; blanking is forced to black.
  always_comb begin
    w_rgb = {(3*CW){1'b0}};
    if (w_vde) begin
      case (r_active_mode)
        2'd0: w_rgb = vid.solid_rgb;
        2'd1: begin
          if (r_bars_done) begin
            w_rgb = {(3*CW){1'b0}};
          end else begin
            w_rgb = {{CW{w_bar_rgb[2]}}, {CW{w_bar_rgb[1]}}, {CW{w_bar_rgb[0]}}};
          end
        end
        2'd2: begin
          if (w_h32[CHECK_LOG2] ^ w_v32[CHECK_LOG2]) begin
            w_rgb = {(3*CW){1'b1}};
          end else begin
            w_rgb = {(3*CW){1'b0}};
          end
        end
        2'd3: begin
          if (w_in_bar) begin
            w_rgb = {(3*CW){1'b1}};
          end else begin
            w_rgb = vid.solid_rgb;
          end
        end
        default: w_rgb = {(3*CW){1'b0}};
      endcase
    end else begin
      w_rgb = {(3*CW){1'b0}};
    end
  end

  // Output register stage keeps video, syncs and coordinates mutually aligned.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_r_data      <= {CW{1'b0}};
      r_g_data      <= {CW{1'b0}};
      r_b_data      <= {CW{1'b0}};
      r_vde         <= 1'b0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_x           <= {XW{1'b0}};
      r_y           <= {XW{1'b0}};
      r_frame_start <= 1'b0;
    end else begin
      r_r_data      <= w_rgb[3*CW-1:2*CW];
      r_g_data      <= w_rgb[2*CW-1:CW];
      r_b_data      <= w_rgb[CW-1:0];
      r_vde         <= w_vde;
      r_hsync       <= w_hs_act ? SYNC_ON : SYNC_OFF;
      r_vsync       <= w_vs_act ? SYNC_ON : SYNC_OFF;
      r_x           <= XW'(r_h_cnt);
      r_y           <= XW'(r_v_cnt);
      r_frame_start <= (r_h_cnt == {HCW{1'b0}}) && (r_v_cnt == {VCW{1'b0}});
    end
  end

  assign vid.R_data      = r_r_data;
  assign vid.G_data      = r_g_data;
  assign vid.B_data      = r_b_data;
  assign vid.VDE         = r_vde;
  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.frame_start = r_frame_start;
  assign vid.frame_cnt   = r_frame_cnt;

endmodule
